// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run controller for cpu_main: reset sequencing, cycle count, halt/timeout stop
module cpu_run_ctrl #(
  parameter int PC_W        = 16,
  parameter int CNT_W       = 16,
  parameter int RST_HOLD    = 4,
  parameter int STALL_LIMIT = 8,
  parameter int TIMEOUT     = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [PC_W-1:0]  i_pc_in,
  output logic             o_core_rst,
  output logic             o_core_run,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic             o_halted,
  output logic             o_timeout,
  output logic             o_done
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [HW-1:0]    HOLD_LAST  = HW'(RST_HOLD - 1);
  localparam logic [SW-1:0]    STALL_LAST = SW'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [HW-1:0]    r_hold_cnt;
  logic [SW-1:0]    r_stall_cnt;
  logic [PC_W-1:0]  r_pc_q;
  logic             r_pc_vld;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic             r_core_rst;
  logic             r_core_run;
  logic             r_halted;
  logic             r_timeout;
  logic             r_done;

  logic             w_pc_eq;
  logic [SW-1:0]    w_stall_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_hit_halt;
  logic             w_hit_to;

  // stall_cnt counts repeats, so the STALL_LIMIT-th equal sample sees STALL_LIMIT-1
  assign w_pc_eq     = r_pc_vld && (i_pc_in == r_pc_q);
  assign w_stall_nxt = r_stall_cnt + 1'b1;
  assign w_cnt_nxt   = r_cycle_cnt + 1'b1;
  assign w_hit_halt  = w_pc_eq && (w_stall_nxt == STALL_LAST);
  assign w_hit_to    = (w_cnt_nxt == TIMEOUT_C);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_hold_cnt  <= '0;
      r_stall_cnt <= '0;
      r_pc_q      <= '0;
      r_pc_vld    <= 1'b0;
      r_cycle_cnt <= '0;
      r_core_rst  <= 1'b1;
      r_core_run  <= 1'b0;
      r_halted    <= 1'b0;
      r_timeout   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_stall_cnt <= '0;
            r_pc_vld    <= 1'b0;
            r_cycle_cnt <= '0;
            r_core_rst  <= 1'b1;
            r_core_run  <= 1'b0;
            r_halted    <= 1'b0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= S_RUN;
            r_core_rst <= 1'b0;
            r_core_run <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        S_RUN: begin
          r_cycle_cnt <= w_cnt_nxt;
          r_pc_q      <= i_pc_in;
          r_pc_vld    <= 1'b1;
          r_stall_cnt <= w_pc_eq ? w_stall_nxt : '0;
          if (w_hit_halt || w_hit_to) begin
            r_state    <= S_DONE;
            r_halted   <= w_hit_halt;
            r_timeout  <= w_hit_to;
            r_done     <= 1'b1;
            r_core_rst <= 1'b1;
            r_core_run <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_core_rst  = r_core_rst;
  assign o_core_run  = r_core_run;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_halted    = r_halted;
  assign o_timeout   = r_timeout;
  assign o_done      = r_done;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed-vector bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_pc_in;
  logic        o_core_rst;
  logic        o_core_run;
  logic [15:0] o_cycle_cnt;
  logic        o_halted;
  logic        o_timeout;
  logic        o_done;

  int n_vec;
  int n_miss;

  // flag order: {core_rst, core_run, halted, timeout, done}
  localparam logic [31:0] F_IDLE = 32'b10000;
  localparam logic [31:0] F_RUN  = 32'b01000;
  localparam logic [31:0] F_HALT = 32'b10101;
  localparam logic [31:0] F_TO   = 32'b10011;
  localparam logic [31:0] F_BOTH = 32'b10111;

  logic [4:0] w_flags;
  assign w_flags = {o_core_rst, o_core_run, o_halted, o_timeout, o_done};

  cpu_run_ctrl #(
    .PC_W(16), .CNT_W(16), .RST_HOLD(4), .STALL_LIMIT(8), .TIMEOUT(20)
  ) u_dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_pc_in     (i_pc_in),
    .o_core_rst  (o_core_rst),
    .o_core_run  (o_core_run),
    .o_cycle_cnt (o_cycle_cnt),
    .o_halted    (o_halted),
    .o_timeout   (o_timeout),
    .o_done      (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // start pulse, then core_rst must stay high for exactly 4 cycles before RUN
  task automatic start_run(input string tag);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk_vec({tag, "_cleared_cnt"}, 32'(o_cycle_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk_vec({tag, "_hold"}, 32'(w_flags), F_IDLE);
      tick();
    end
    chk_vec({tag, "_run"}, 32'(w_flags), F_RUN);
    chk_vec({tag, "_run_cnt"}, 32'(o_cycle_cnt), 32'd0);
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    i_rst   = 1'b0;
    i_start = 1'b0;
    i_pc_in = 16'h0000;
    tick();
    tick();
    chk_vec("reset_flags", 32'(w_flags), F_IDLE);
    chk_vec("reset_cnt", 32'(o_cycle_cnt), 32'd0);
    i_rst = 1'b1;
    tick();
    chk_vec("idle_flags", 32'(w_flags), F_IDLE);

    // run A: pc climbs to 0x0010 then holds; 8th sample of 0x0010 is RUN cycle 13
    start_run("t1");
    for (int r = 1; r <= 13; r++) begin
      i_pc_in = (r <= 5) ? 16'(16'h000A + r) : 16'h0010;
      tick();
      if (r == 12) begin
        chk_vec("t2_pre_flags", 32'(w_flags), F_RUN);
        chk_vec("t2_pre_cnt", 32'(o_cycle_cnt), 32'd12);
      end
    end
    chk_vec("t2_halt_flags", 32'(w_flags), F_HALT);
    chk_vec("t2_halt_cnt", 32'(o_cycle_cnt), 32'd13);

    // run B: restart from DONE, pc always increments, start pulsed mid-RUN
    start_run("t6");
    for (int r = 1; r <= 20; r++) begin
      i_pc_in = 16'(16'h0100 + r);
      i_start = (r == 5);
      tick();
      if (r == 5) chk_vec("t6_start_ignored", 32'(w_flags), F_RUN);
      if (r == 19) chk_vec("t3_pre_cnt", 32'(o_cycle_cnt), 32'd19);
    end
    i_start = 1'b0;
    chk_vec("t3_to_flags", 32'(w_flags), F_TO);
    chk_vec("t3_to_cnt", 32'(o_cycle_cnt), 32'd20);
    for (int i = 0; i < 10; i++) begin
      i_pc_in = 16'(16'h0200 + i);
      tick();
    end
    chk_vec("t3_hold_flags", 32'(w_flags), F_TO);
    chk_vec("t3_hold_cnt", 32'(o_cycle_cnt), 32'd20);

    // run C: pc constant from cycle 13 so the 8th equal sample lands on cycle 20
    start_run("t4");
    for (int r = 1; r <= 20; r++) begin
      i_pc_in = (r <= 12) ? 16'(16'h0200 + r) : 16'h0300;
      tick();
      if (r == 19) chk_vec("t4_pre_flags", 32'(w_flags), F_RUN);
    end
    chk_vec("t4_both_flags", 32'(w_flags), F_BOTH);
    chk_vec("t4_both_cnt", 32'(o_cycle_cnt), 32'd20);

    // run D: pc equals last run's final pc from cycle 1; first sample must not count
    start_run("t7");
    for (int r = 1; r <= 8; r++) begin
      i_pc_in = 16'h0300;
      tick();
      if (r == 7) chk_vec("t7_pre_flags", 32'(w_flags), F_RUN);
    end
    chk_vec("t7_halt_flags", 32'(w_flags), F_HALT);
    chk_vec("t7_halt_cnt", 32'(o_cycle_cnt), 32'd8);

    // run E: async reset between edges mid-RUN
    start_run("t5");
    for (int r = 1; r <= 5; r++) begin
      i_pc_in = 16'(16'h0400 + r);
      tick();
    end
    chk_vec("t5_pre_cnt", 32'(o_cycle_cnt), 32'd5);
    #2 i_rst = 1'b0;
    #1;
    chk_vec("t5_async_flags", 32'(w_flags), F_IDLE);
    chk_vec("t5_async_cnt", 32'(o_cycle_cnt), 32'd0);
    tick();
    i_rst = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk_vec("t5_idle_flags", 32'(w_flags), F_IDLE);
    chk_vec("t5_idle_cnt", 32'(o_cycle_cnt), 32'd0);
    start_run("t5b");
    i_pc_in = 16'h0500;
    tick();
    chk_vec("t5b_cnt", 32'(o_cycle_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
